binary_bcd_seq: RTL and testbench

BINARY_BCD_SEQ -- requirements
Module: binary_bcd_seq

---
 rtl/binary_bcd_seq.sv | 132 +++++++++++++
 tb/tb_binary_bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/binary_bcd_seq.sv
// binary_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// One bit is consumed per clock; results, leading-zero blanking and the
// overflow flag are registered and held until the next conversion ends.
module binary_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | one double-dabble step per cycle, counter counts down
  // DONE  | one-cycle done pulse; start here chains the next conversion

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_shift;
  logic [BW-1:0]     r_scratch;
  logic              r_ovf_acc;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bcd;
  logic [DIGITS-1:0] r_blank;
  logic              r_ovf;

  logic              w_accept;
  logic              w_last;
  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_scratch_nxt;
  logic              w_ovf_bit;
  logic [DIGITS-1:0] w_blank_nxt;
  logic              w_zero_above;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(1));

  // Add-3 adjust of every scratch digit that is 5 or more
  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // Top scratch bit about to be shifted out means the value no longer fits
  assign w_ovf_bit     = w_adj[BW-1];
  assign w_scratch_nxt = {w_adj[BW-2:0], r_shift[WIDTH-1]};

  // Leading-zero blanking of the final scratch; the ones digit is never blanked
  always_comb begin
    w_blank_nxt  = '0;
    w_zero_above = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      w_zero_above   = w_zero_above && (w_scratch_nxt[4*d +: 4] == 4'd0);
      w_blank_nxt[d] = w_zero_above;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Conversion datapath: load on accept, step while shifting, latch result on last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_ovf_acc <= 1'b0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_blank   <= BLANK_RST;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= binary;
      r_scratch <= '0;
      r_ovf_acc <= 1'b0;
      r_cnt     <= CW'(WIDTH);
    end else if (r_state == S_SHIFT) begin
      r_shift   <= r_shift << 1;
      r_scratch <= w_scratch_nxt;
      r_ovf_acc <= r_ovf_acc | w_ovf_bit;
      r_cnt     <= r_cnt - CW'(1);
      if (w_last) begin
        r_bcd   <= w_scratch_nxt;
        r_blank <= w_blank_nxt;
        r_ovf   <= r_ovf_acc | w_ovf_bit;
      end
    end
  end

  // Outputs decode only from registers, so no input reaches an output combinationally
  always_comb begin
    busy     = (r_state == S_SHIFT);
    done     = (r_state == S_DONE);
    bcd      = r_bcd;
    blank    = r_blank;
    overflow = r_ovf;
  end

endmodule

// File: tb/tb_binary_bcd_seq.sv
// Directed bench for binary_bcd_seq: three instances (8b/3d, 8b/2d, 16b/5d)
// sharing clock and reset; outputs sampled on the falling edge.
module tb_binary_bcd_seq;

  logic clk;
  logic rst_n;

  logic        start_a, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;
  logic [2:0]  blank_a;

  logic        start_b, busy_b, done_b, ovf_b;
  logic [7:0]  bin_b;
  logic [7:0]  bcd_b;
  logic [1:0]  blank_b;

  logic        start_c, busy_c, done_c, ovf_c;
  logic [15:0] bin_c;
  logic [19:0] bcd_c;
  logic [4:0]  blank_c;

  int n_checks = 0;
  int n_err    = 0;
  int sel      = 0;

  logic        m_busy, m_done, m_ovf;
  logic [19:0] m_bcd;
  logic [4:0]  m_blank;

  binary_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .binary(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .blank(blank_a), .overflow(ovf_a));

  binary_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .binary(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .blank(blank_b), .overflow(ovf_b));

  binary_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .binary(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .blank(blank_c), .overflow(ovf_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_busy  = busy_a;
    m_done  = done_a;
    m_ovf   = ovf_a;
    m_bcd   = {8'h00, bcd_a};
    m_blank = {2'b00, blank_a};
    case (sel)
      1: begin
        m_busy = busy_b; m_done = done_b; m_ovf = ovf_b;
        m_bcd = {12'h000, bcd_b}; m_blank = {3'b000, blank_b};
      end
      2: begin
        m_busy = busy_c; m_done = done_c; m_ovf = ovf_c;
        m_bcd = bcd_c; m_blank = blank_c;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic st, input logic [15:0] b);
    case (s)
      0: begin start_a = st; bin_a = b[7:0]; end
      1: begin start_b = st; bin_b = b[7:0]; end
      default: begin start_c = st; bin_c = b; end
    endcase
  endtask

  // Called at a falling edge; a glitch_at of k pulses start (with another
  // value) at falling edge k of the conversion, which must be ignored.
  task automatic convert(input int s, input int w, input logic [15:0] bin,
                         input logic [19:0] e_bcd, input logic [4:0] e_blank,
                         input logic e_ovf, input int glitch_at, input string tag);
    int busy_n;
    int done_n;
    sel = s;
    drive(s, 1'b1, bin);
    @(negedge clk);
    drive(s, 1'b0, bin);
    busy_n = 0;
    done_n = 0;
    for (int k = 1; k <= w; k++) begin
      if (m_busy) busy_n++;
      if (m_done) done_n++;
      if (glitch_at != 0 && k == glitch_at) drive(s, 1'b1, bin ^ 16'h00AA);
      else drive(s, 1'b0, bin);
      @(negedge clk);
    end
    drive(s, 1'b0, bin);
    chk({tag, "_busy_cycles"}, busy_n, w);
    chk({tag, "_early_done"}, done_n, 0);
    chk({tag, "_done"}, m_done, 1'b1);
    chk({tag, "_busy_end"}, m_busy, 1'b0);
    chk({tag, "_bcd"}, m_bcd, e_bcd);
    chk({tag, "_blank"}, m_blank, e_blank);
    chk({tag, "_ovf"}, m_ovf, e_ovf);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, m_done, 1'b0);
    chk({tag, "_idle_busy"}, m_busy, 1'b0);
  endtask

  initial begin
    int cnt;
    int n_done;
    rst_n = 1'b1;
    drive(0, 1'b0, 16'h0);
    drive(1, 1'b0, 16'h0);
    drive(2, 1'b0, 16'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_bcd", bcd_a, 12'h000);
    chk("rst_blank_a", blank_a, 3'b110);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_blank_b", blank_b, 2'b10);
    chk("rst_blank_c", blank_c, 5'b11110);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First conversion starts on the very first edge after release
    convert(0, 8, 16'd255, 20'h00255, 5'b000, 1'b0, 0, "a255");
    convert(0, 8, 16'd0,   20'h00000, 5'b110, 1'b0, 0, "a0");
    convert(0, 8, 16'd7,   20'h00007, 5'b110, 1'b0, 0, "a7");
    convert(0, 8, 16'd42,  20'h00042, 5'b100, 1'b0, 0, "a42");
    convert(0, 8, 16'd100, 20'h00100, 5'b000, 1'b0, 3, "a_glitch");

    // Asynchronous reset in the middle of SHIFT cycle 4
    sel = 0;
    drive(0, 1'b1, 16'd200);
    @(negedge clk);
    drive(0, 1'b0, 16'd200);
    repeat (3) @(negedge clk);
    chk("rst_mid_pre_busy", m_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", m_busy, 1'b0);
    chk("rst_mid_done", m_done, 1'b0);
    chk("rst_mid_bcd", m_bcd, 20'h0);
    chk("rst_mid_blank", m_blank, 5'b110);
    chk("rst_mid_ovf", m_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_done || m_busy) cnt++;
    end
    chk("rst_mid_no_done", cnt, 0);
    convert(0, 8, 16'd123, 20'h00123, 5'b000, 1'b0, 0, "a123");

    convert(1, 8, 16'd200, 20'h00000, 5'b10, 1'b1, 0, "b200");
    convert(1, 8, 16'd99,  20'h00099, 5'b00, 1'b0, 0, "b99");

    // Start held high: back-to-back conversions on the 16-bit instance
    sel = 2;
    drive(2, 1'b1, 16'd65535);
    n_done = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (m_done) n_done++;
      if (k == 1) drive(2, 1'b1, 16'd1000);
      if (k == 17) begin
        chk("c_first_done", m_done, 1'b1);
        chk("c_first_bcd", m_bcd, 20'h65535);
        chk("c_first_blank", m_blank, 5'b00000);
        chk("c_first_ovf", m_ovf, 1'b0);
      end
      if (k == 34) begin
        chk("c_second_done", m_done, 1'b1);
        chk("c_second_bcd", m_bcd, 20'h01000);
        chk("c_second_blank", m_blank, 5'b10000);
        drive(2, 1'b0, 16'd1000);
      end
    end
    chk("c_done_count", n_done, 2);
    @(negedge clk);
    chk("c_idle_busy", m_busy, 1'b0);
    chk("c_idle_done", m_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
